seven_segment_scanner: RTL



---
 rtl/seven_segment_scanner.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// seven_segment_scanner
//
// Purpose:
//   Time-multiplexed driver for a 4-digit common-anode seven-segment display.
//   - Decodes each 4-bit digit to hex segments.
//   - Scans the four digits in turn.
//   - Blanks all anodes for the first GUARD clocks of every slot, which stops
//     one digit ghosting onto the next.
//   - Optionally suppresses leading zeros.
//   - Optionally blinks selected digits.
//   The inputs are copied into shadow registers once per frame, on the tick
//   that leaves digit 3 and enters digit 0. A frame therefore never mixes old
//   and new values.
//
// Parameters:
//   REFRESH_W : each digit slot lasts 2^REFRESH_W clocks
//   GUARD     : number of all-anodes-off clocks at the start of a slot
//               (must be < 2^REFRESH_W)
//   BLINK_W   : blink counter width; the blink phase is its MSB
//
// Ports:
//   clock          in   system clock, all state changes on the rising edge
//   reset_n        in   synchronous reset, active low
//   number[15:0]   in   value to show; digit i = number[4i+3:4i], digit 0 right
//   dots[3:0]      in   dots[i] lights the decimal point of digit i
//   blank_leading  in   1 = suppress leading zeros
//   blink_mask[3:0]in   blink_mask[i] = 1 makes digit i blink
//   seven_segments out  active-low segments, bit0 = a ... bit6 = g
//   dot            out  active-low decimal point
//   anodes[3:0]    out  active-low digit enables, anodes[i] = 0 enables digit i
// -----------------------------------------------------------------------------
module seven_segment_scanner #(
   parameter int REFRESH_W = 16,
   parameter int GUARD     = 4,
   parameter int BLINK_W   = 24
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [15:0] number,
   input  logic [3:0]  dots,
   input  logic        blank_leading,
   input  logic [3:0]  blink_mask,
   output logic [6:0]  seven_segments,
   output logic        dot,
   output logic [3:0]  anodes
);

   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic [3:0] AN_OFF  = 4'b1111;

   // Scan state
   logic [REFRESH_W-1:0] refresh_q, refresh_d;
   logic [1:0]           digit_q, digit_d;
   logic [BLINK_W-1:0]   blink_q, blink_d;

   // Shadow copies of the inputs, refreshed once per frame
   logic [15:0] number_sh_q, number_sh_d;
   logic [3:0]  dots_sh_q, dots_sh_d;
   logic        blank_sh_q, blank_sh_d;
   logic [3:0]  blink_sh_q, blink_sh_d;

   // Registered outputs
   logic [6:0] seg_q, seg_d;
   logic       dot_q, dot_d;
   logic [3:0] an_q, an_d;

   // Per-digit helpers
   logic [3:0] digit_zero;
   logic [3:0] digit_blank;

   logic       tick;
   logic       capture;
   logic [3:0] cur_nibble;
   logic       cur_blank;
   logic       cur_dot;
   logic       cur_blink;
   logic       blink_phase;
   logic       in_guard;
   logic       slot_off;

   // A digit is blank when blanking is enabled and it and every digit to
   // its left are zero. Digit 0 always shows, so a zero value reads "0".
   for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign digit_zero[gi] = (number_sh_q[4*gi +: 4] == 4'h0);
      if (gi == 0) begin : g_rightmost
         assign digit_blank[gi] = 1'b0;
      end else begin : g_upper
         assign digit_blank[gi] = blank_sh_q & (&digit_zero[3:gi]);
      end
   end

   function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
      logic [6:0] seg;
      seg = SEG_OFF;
      case (value)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = SEG_OFF;
      endcase
      return seg;
   endfunction

   always_comb begin
      // Counters
      tick      = &refresh_q;
      refresh_d = refresh_q + REFRESH_W'(1);
      blink_d   = blink_q + BLINK_W'(1);
      digit_d   = digit_q;
      if (tick) begin
         digit_d = digit_q + 2'd1;
      end

      // Inputs are sampled only as the scan wraps from digit 3 to digit 0.
      capture     = tick && (digit_q == 2'd3);
      number_sh_d = number_sh_q;
      dots_sh_d   = dots_sh_q;
      blank_sh_d  = blank_sh_q;
      blink_sh_d  = blink_sh_q;
      if (capture) begin
         number_sh_d = number;
         dots_sh_d   = dots;
         blank_sh_d  = blank_leading;
         blink_sh_d  = blink_mask;
      end

      // Current slot
      cur_nibble  = number_sh_q[{digit_q, 2'b00} +: 4];
      cur_blank   = digit_blank[digit_q];
      cur_dot     = dots_sh_q[digit_q];
      cur_blink   = blink_sh_q[digit_q];
      blink_phase = blink_q[BLINK_W-1];
      in_guard    = (refresh_q < REFRESH_W'(GUARD));

      // A blank digit whose decimal point is lit keeps its anode on, so the
      // point can still show.
      slot_off = in_guard || (cur_blink && blink_phase) || (cur_blank && !cur_dot);

      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dot_d = 1'b1;
      if (!slot_off) begin
         an_d  = ~(4'b0001 << digit_q);
         seg_d = cur_blank ? SEG_OFF : hex_to_seg(cur_nibble);
         dot_d = ~cur_dot;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         refresh_q   <= '0;
         digit_q     <= '0;
         blink_q     <= '0;
         number_sh_q <= '0;
         dots_sh_q   <= '0;
         blank_sh_q  <= 1'b0;
         blink_sh_q  <= '0;
         seg_q       <= SEG_OFF;
         dot_q       <= 1'b1;
         an_q        <= AN_OFF;
      end else begin
         refresh_q   <= refresh_d;
         digit_q     <= digit_d;
         blink_q     <= blink_d;
         number_sh_q <= number_sh_d;
         dots_sh_q   <= dots_sh_d;
         blank_sh_q  <= blank_sh_d;
         blink_sh_q  <= blink_sh_d;
         seg_q       <= seg_d;
         dot_q       <= dot_d;
         an_q        <= an_d;
      end
   end

   assign seven_segments = seg_q;
   assign dot            = dot_q;
   assign anodes         = an_q;

endmodule
